rom_stream_reader: RTL and testbench
====================================

# rom_stream_reader

Read sequencer that sits directly in front of the 16K×24 synchronous ROM. It sources the ROM address and output enable and walks a contiguous address window given by a start command. It captures each ROM word one cycle after the address is registered and delivers the words in address order on a valid/ready stream, through a small FIFO so that downstream back-pressure never drops data.

## Interface
- `AW`, 14, ROM address width.
- `DW`, 24, ROM data width.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:
- `CK` input 1: single clock, rising edge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `START` input 1: one-cycle command pulse, sampled only in IDLE.
- `BASE` input AW: first word address, sampled with `START`.
- `LEN` input AW+1: number of words to read (0..16384), sampled with `START`.
- `BUSY` output 1: high in RUN or DRAIN.
- `DONE` output 1: one-cycle pulse when a command completes.
- `ROM_A` output AW: ROM address.
- `ROM_OE` output 1: ROM output enable.
- `ROM_Q` input DW: ROM data.
- `OUT_DATA` output DW: FIFO head word.
- `OUT_VALID` output 1: FIFO non-empty.
- `OUT_READY` input 1: consumer accepts on any edge where `OUT_VALID && OUT_READY`.
- `CHECKSUM` output DW: present only with `ROM_RD_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: on `START` with `LEN`≠0 → RUN; load `addr`=`BASE`, `remain`=`LEN`.
  - IDLE: on `START` with `LEN`=0 → `DONE` pulse next cycle, stay IDLE.
  - RUN: the cycle that issues the last address moves the FSM to DRAIN.
  - DRAIN: when `inflight`=0 and the FIFO is empty → IDLE, with a `DONE` pulse in the cycle after.
- `START` in RUN or DRAIN is ignored; no queuing.
- `ROM_A` = `addr` register at all times. `ROM_OE` = `BUSY`.
- Issue condition, evaluated in RUN: `fifo_count + inflight < FIFO_DEPTH`.
  - On issue, `addr` increments modulo 2^AW (0x3FFF wraps to 0x0000), `remain` decrements, and `inflight` is set.
  - Without issue, `inflight` clears.
  - `ROM_A` is re-latched by the ROM every cycle; words not issued are never captured.
- Capture: on an edge where `inflight`=1, `ROM_Q` is written to the FIFO tail.
- Simultaneous FIFO push and pop in one edge: count unchanged, data order preserved.
- Words leave in strictly increasing (wrapping) address order; no word is dropped or duplicated under any `OUT_READY` pattern.

## Timing
- Reset values: `BUSY`=0, `DONE`=0, `ROM_A`=0, `ROM_OE`=0, `OUT_VALID`=0, `OUT_DATA`=0, `CHECKSUM`=0; FSM in IDLE, FIFO empty, `inflight`=0.
- `START` sampled at edge t0. `ROM_A`=`BASE` during cycle t0→t1. ROM registers it at t1. Word captured at t2. `OUT_VALID` is high after t2: 2-cycle latency.
- With `OUT_READY` held high: one word per cycle; the FIFO does not fill.
- With `OUT_READY` low: at most `FIFO_DEPTH` words are buffered, then issue stalls with `ROM_A` held. Issue resumes the cycle after the first pop.
- Total command time with `OUT_READY` high: `LEN`+2 edges to last capture; `DONE` follows once the last word is popped.
- `RST_N` asserted mid-command: everything returns to reset values immediately. The FIFO contents are discarded and no `DONE` is produced.

## Configuration
- `ROM_RD_CHECKSUM_EN` defined: adds output `CHECKSUM`, a DW-bit XOR of every word popped since the last accepted `START`.
  - Cleared on accepted `START`.
  - Valid and stable from the `DONE` pulse until the next accepted `START`.
- `ROM_RD_CHECKSUM_EN` undefined: no `CHECKSUM` port and no accumulator logic. All other behaviour is identical.

## Test plan
- Reset mid-RUN (`BASE`=0x0100, `LEN`=64, `RST_N` low at word 10) → all outputs 0 asynchronously; no `DONE`; a fresh `START` afterwards works normally.
- `BASE`=0x0010, `LEN`=8, `OUT_READY`=1, ROM[a]=a+0x100000 → `OUT_VALID` 2 cycles after `START`; 8 consecutive words 0x100010..0x100017; `DONE` once; `BUSY` low after.
- `BASE`=0x3FFE, `LEN`=4 → words read from 0x3FFE, 0x3FFF, 0x0000, 0x0001 in that order.
- `LEN`=20 with `OUT_READY` low for 10 cycles, then toggling every cycle → `ROM_A` frozen while the FIFO holds 4 words; all 20 words delivered in order, none lost or duplicated.
- `LEN`=0 → `DONE` pulse with `BUSY` never high; a second `START` issued during a RUN is ignored, and the original command completes with its own `LEN`.
- With `ROM_RD_CHECKSUM_EN` and words 0x000001, 0x000002, 0x000004 → `CHECKSUM`=0x000007 at `DONE`.

Source files
------------

// File: rtl/rom_stream_reader_if.sv
// Stream-reader bundle: command, status, ROM port and output stream.
// No logic of its own; it carries the ROM address/data and the valid/ready stream.
// Back-pressure rides on OUT_READY; the ROM side has none.
interface rom_stream_reader_if #(
    parameter int AW = 14,
    parameter int DW = 24
);
    logic          START;
    logic [AW-1:0] BASE;
    logic [AW:0]   LEN;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] ROM_A;
    logic          ROM_OE;
    logic [DW-1:0] ROM_Q;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
`ifdef ROM_RD_CHECKSUM_EN
    logic [DW-1:0] CHECKSUM;

    modport master (
        input  START, BASE, LEN, ROM_Q, OUT_READY,
        output BUSY, DONE, ROM_A, ROM_OE, OUT_DATA, OUT_VALID, CHECKSUM
    );
    modport slave (
        output START, BASE, LEN, ROM_Q, OUT_READY,
        input  BUSY, DONE, ROM_A, ROM_OE, OUT_DATA, OUT_VALID, CHECKSUM
    );
`else
    modport master (
        input  START, BASE, LEN, ROM_Q, OUT_READY,
        output BUSY, DONE, ROM_A, ROM_OE, OUT_DATA, OUT_VALID
    );
    modport slave (
        output START, BASE, LEN, ROM_Q, OUT_READY,
        input  BUSY, DONE, ROM_A, ROM_OE, OUT_DATA, OUT_VALID
    );
`endif
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a ROM address window and streams the words out in address order (optional ROM_RD_CHECKSUM_EN adds CHECKSUM).
// Latency: START edge to OUT_VALID is 2 cycles; one word per cycle when OUT_READY stays high.
// Back-pressure: issue stalls (ROM_A held) once FIFO words plus the in-flight read reach FIFO_DEPTH.
module rom_stream_reader #(
    parameter int AW         = 14,
    parameter int DW         = 24,
    parameter int FIFO_DEPTH = 4
) (
    input logic              CK,
    input logic              RST_N,
    rom_stream_reader_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr;
    logic [AW:0]   remain;
    logic          inflight;
    logic          done_r;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;

    logic accept, issue, done_set, push, pop;

    // A word reserves its FIFO slot from the cycle its address is issued.
    assign occupancy = count + CW'(inflight);
    assign push      = inflight;
    assign pop       = (count != '0) && bus.OUT_READY;

    // State register.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, command acceptance, issue decision and completion.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    accept = 1'b1;
                    if (bus.LEN != '0) state_nxt = RUN;
                    else               done_set  = 1'b1;
                end
            end
            RUN: begin
                if (occupancy < CW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (remain == (AW+1)'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && count == '0) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address walker; addr wraps naturally at 2^AW.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            addr     <= '0;
            remain   <= '0;
            inflight <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (accept) begin
                addr   <= bus.BASE;
                remain <= bus.LEN;
            end else if (issue) begin
                addr   <= addr + AW'(1);
                remain <= remain - (AW+1)'(1);
            end
            inflight <= issue;
            done_r   <= done_set;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge CK) begin
        if (push) mem[wr_ptr] <= bus.ROM_Q;
    end

`ifdef ROM_RD_CHECKSUM_EN
    logic [DW-1:0] cksum;

    // XOR of every popped word since the last accepted command.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N)      cksum <= '0;
        else if (accept) cksum <= '0;
        else if (pop)    cksum <= cksum ^ mem[rd_ptr];
    end

    assign bus.CHECKSUM = cksum;
`endif

    assign bus.BUSY      = (state != IDLE);
    assign bus.ROM_OE    = (state != IDLE);
    assign bus.DONE      = done_r;
    assign bus.ROM_A     = addr;
    assign bus.OUT_VALID = (count != '0);
    assign bus.OUT_DATA  = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a behavioural synchronous ROM.
// Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
// Popped words are collected and compared against hand-derived address sequences.
module tb_rom_stream_reader;
    logic CK;
    logic RST_N;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   rom_mode;
    logic [23:0] got[$];
    logic [23:0] cksum_at_done;

    rom_stream_reader_if #(.AW(14), .DW(24)) bus ();

    rom_stream_reader #(.AW(14), .DW(24), .FIFO_DEPTH(4)) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic logic [23:0] rom_word(input logic [13:0] a);
        if (rom_mode == 1) return 24'h1 << a[4:0];
        return 24'h100000 + {10'b0, a};
    endfunction

    // Synchronous ROM: address registered every edge, data valid after it.
    always @(posedge CK) bus.ROM_Q <= rom_word(bus.ROM_A);

    // Consumer side: a word is taken at the next edge when valid and ready.
    always @(negedge CK) begin
        if (bus.OUT_VALID && bus.OUT_READY) got.push_back(bus.OUT_DATA);
        if (bus.DONE) begin
            done_cnt++;
`ifdef ROM_RD_CHECKSUM_EN
            cksum_at_done = bus.CHECKSUM;
`else
            cksum_at_done = 24'h0;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_start(input logic [13:0] base, input logic [14:0] len);
        @(posedge CK);
        #1;
        bus.START = 1'b1;
        bus.BASE  = base;
        bus.LEN   = len;
        @(posedge CK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge CK);
            #1;
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_words(input string tag, input logic [13:0] base, input int len);
        logic [13:0] a;
        chk({tag, "_count"}, 32'(got.size()), 32'(len));
        for (int i = 0; i < len && i < got.size(); i++) begin
            a = base + 14'(i);
            chk($sformatf("%s_w%0d", tag, i), {8'h0, got[i]}, {8'h0, 24'h100000 + {10'b0, a}});
        end
    endtask

    initial begin
        int d0;
        int n;
        n_checks      = 0;
        n_errors      = 0;
        done_cnt      = 0;
        rom_mode      = 0;
        cksum_at_done = '0;
        RST_N         = 1'b0;
        bus.START     = 1'b0;
        bus.BASE      = '0;
        bus.LEN       = '0;
        bus.OUT_READY = 1'b1;
        repeat (3) @(posedge CK);
        @(negedge CK);
        chk("rst_busy",   32'(bus.BUSY),      32'd0);
        chk("rst_done",   32'(bus.DONE),      32'd0);
        chk("rst_rom_a",  32'(bus.ROM_A),     32'd0);
        chk("rst_rom_oe", 32'(bus.ROM_OE),    32'd0);
        chk("rst_valid",  32'(bus.OUT_VALID), 32'd0);
        chk("rst_data",   32'(bus.OUT_DATA),  32'd0);
        @(posedge CK);
        #1 RST_N = 1'b1;

        // Basic run: 2-cycle latency then one word per cycle.
        got.delete();
        d0 = done_cnt;
        do_start(14'h0010, 15'd8);
        @(negedge CK);
        chk("b_busy",   32'(bus.BUSY),   32'd1);
        chk("b_oe",     32'(bus.ROM_OE), 32'd1);
        chk("b_rom_a",  32'(bus.ROM_A),  32'h10);
        chk("b_val_t0", 32'(bus.OUT_VALID), 32'd0);
        @(negedge CK);
        chk("b_val_t1", 32'(bus.OUT_VALID), 32'd0);
        @(negedge CK);
        chk("b_val_t2", 32'(bus.OUT_VALID), 32'd1);
        chk("b_dat_t2", 32'(bus.OUT_DATA),  32'h100010);
        wait_done("b", d0, 100);
        check_words("b", 14'h0010, 8);
        chk("b_done_once", 32'(done_cnt - d0), 32'd1);
        chk("b_busy_end",  32'(bus.BUSY), 32'd0);

        // Address wrap at the top of the ROM.
        got.delete();
        d0 = done_cnt;
        do_start(14'h3FFE, 15'd4);
        wait_done("w", d0, 100);
        check_words("w", 14'h3FFE, 4);

        // Back-pressure: four issued then stall, then a toggling consumer.
        got.delete();
        d0 = done_cnt;
        bus.OUT_READY = 1'b0;
        do_start(14'h0200, 15'd20);
        repeat (8) @(negedge CK);
        chk("bp_rom_a_8",  32'(bus.ROM_A), 32'h204);
        chk("bp_valid",    32'(bus.OUT_VALID), 32'd1);
        chk("bp_head",     32'(bus.OUT_DATA), 32'h100200);
        repeat (2) @(negedge CK);
        chk("bp_rom_a_10", 32'(bus.ROM_A), 32'h204);
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge CK);
            #1 bus.OUT_READY = ~bus.OUT_READY;
            n++;
        end
        chk("bp_timeout", 32'(n < 300), 32'd1);
        bus.OUT_READY = 1'b1;
        @(negedge CK);
        #1;
        check_words("bp", 14'h0200, 20);

        // Zero-length command: immediate DONE, never busy.
        d0 = done_cnt;
        do_start(14'h0050, 15'd0);
        @(negedge CK);
        chk("z_done", 32'(bus.DONE), 32'd1);
        chk("z_busy", 32'(bus.BUSY), 32'd0);
        @(negedge CK);
        chk("z_done_clr", 32'(bus.DONE), 32'd0);
        chk("z_busy2",    32'(bus.BUSY), 32'd0);
        #1;
        chk("z_done_cnt", 32'(done_cnt - d0), 32'd1);

        // A START while running is dropped, not queued.
        got.delete();
        d0 = done_cnt;
        do_start(14'h0020, 15'd6);
        do_start(14'h0300, 15'd10);
        wait_done("ig", d0, 100);
        repeat (6) @(negedge CK);
        #1;
        check_words("ig", 14'h0020, 6);
        chk("ig_done_once", 32'(done_cnt - d0), 32'd1);
        chk("ig_busy",      32'(bus.BUSY), 32'd0);

        // Reset in the middle of a long command.
        got.delete();
        d0 = done_cnt;
        do_start(14'h0100, 15'd64);
        n = 0;
        while (got.size() < 10 && n < 100) begin
            @(negedge CK);
            #1;
            n++;
        end
        chk("mr_timeout", 32'(n < 100), 32'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("mr_busy",  32'(bus.BUSY),      32'd0);
        chk("mr_rom_a", 32'(bus.ROM_A),     32'd0);
        chk("mr_oe",    32'(bus.ROM_OE),    32'd0);
        chk("mr_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("mr_data",  32'(bus.OUT_DATA),  32'd0);
        chk("mr_done",  32'(bus.DONE),      32'd0);
        repeat (2) @(posedge CK);
        #1 RST_N = 1'b1;
        repeat (6) @(negedge CK);
        #1;
        chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mr_head10",  {8'h0, got[9]}, 32'h100109);
        got.delete();
        do_start(14'h0030, 15'd3);
        wait_done("mr2", d0, 100);
        check_words("mr2", 14'h0030, 3);

`ifdef ROM_RD_CHECKSUM_EN
        // Checksum over words 1, 2, 4.
        rom_mode = 1;
        got.delete();
        d0 = done_cnt;
        do_start(14'h0000, 15'd3);
        wait_done("ck", d0, 100);
        chk("ck_value", {8'h0, cksum_at_done}, 32'h7);
        rom_mode = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
